// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter sharing one SRAM controller path between ports A and B.
// Latches the winning command, holds it until mem_ready or watchdog abort, then returns ready.
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_wr_en,
  input  logic              a_rd_en,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_write_data,
  output logic [DATA_W-1:0] a_read_data,
  output logic              a_ready,
  output logic              a_freeze,
  input  logic              b_wr_en,
  input  logic              b_rd_en,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_write_data,
  output logic [DATA_W-1:0] b_read_data,
  output logic              b_ready,
  output logic              b_freeze,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, DONE} state_t;

  state_t              state_reg, state_next;
  logic                last_b_reg;
  logic                op_wr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [CNT_W-1:0]    wd_cnt_reg;
  logic [DATA_W-1:0]   a_rdata_reg, b_rdata_reg;
  logic                a_ready_reg, b_ready_reg;
  logic                timeout_err_reg;

  logic a_req, b_req, grant_a, grant_b, in_grant, wd_expired, finish;

  assign a_req      = a_wr_en | a_rd_en;
  assign b_req      = b_wr_en | b_rd_en;
  // A wins a tie only when B was the previous winner.
  assign grant_a    = a_req & (~b_req | last_b_reg);
  assign grant_b    = b_req & ~grant_a;
  assign in_grant   = (state_reg == GRANT_A) || (state_reg == GRANT_B);
  assign wd_expired = (wd_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign finish     = in_grant & (mem_ready | wd_expired);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_a)      state_next = GRANT_A;
        else if (grant_b) state_next = GRANT_B;
      end
      GRANT_A, GRANT_B: begin
        if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      last_b_reg      <= 1'b1;
      op_wr_reg       <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wd_cnt_reg      <= '0;
      a_rdata_reg     <= '0;
      b_rdata_reg     <= '0;
      a_ready_reg     <= 1'b0;
      b_ready_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_ready_reg <= 1'b0;
      b_ready_reg <= 1'b0;
      if (state_reg == IDLE && (grant_a || grant_b)) begin
        // A simultaneous wr/rd request collapses to a write.
        addr_reg   <= grant_a ? a_address : b_address;
        wdata_reg  <= grant_a ? a_write_data : b_write_data;
        op_wr_reg  <= grant_a ? a_wr_en : b_wr_en;
        last_b_reg <= grant_b;
        wd_cnt_reg <= '0;
      end
      if (in_grant) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
      if (finish) begin
        if (!mem_ready) timeout_err_reg <= 1'b1;
        if (state_reg == GRANT_A) begin
          a_ready_reg <= 1'b1;
          if (!mem_ready)     a_rdata_reg <= '0;
          else if (!op_wr_reg) a_rdata_reg <= mem_read_data;
        end else begin
          b_ready_reg <= 1'b1;
          if (!mem_ready)     b_rdata_reg <= '0;
          else if (!op_wr_reg) b_rdata_reg <= mem_read_data;
        end
      end
    end
  end

  assign mem_wr_en      = in_grant & op_wr_reg;
  assign mem_rd_en      = in_grant & ~op_wr_reg;
  assign mem_address    = addr_reg;
  assign mem_write_data = wdata_reg;
  assign a_read_data    = a_rdata_reg;
  assign b_read_data    = b_rdata_reg;
  assign a_ready        = a_ready_reg;
  assign b_ready        = b_ready_reg;
  assign timeout_err    = timeout_err_reg;
  assign a_freeze       = a_req & ~a_ready_reg;
  assign b_freeze       = b_req & ~b_ready_reg;

endmodule
